// File: rtl/clk_meter.sv
// clk_meter: gated rising-edge counter for one divided clock.
// Reports edges per window against the 50 MHz system clock, with range check.
module clk_meter #(
    parameter int GATE_CYCLES = 50000,
    parameter int CNT_W       = 16,
    parameter int EXP_MIN     = 990,
    parameter int EXP_MAX     = 1010
) (
    input  logic             clk_50MHz,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             overflow,
    output logic             busy
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [31:0]      LIM_LO    = 32'(EXP_MIN);
    localparam logic [31:0]      LIM_HI    = 32'(EXP_MAX);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_GATE,
        ST_REPORT
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [1:0]       init_cnt;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf;

    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             range_nxt;
    logic [31:0]      cnt_ext;

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Next window values include the edge seen in the final gate cycle.
    always_comb begin
        cnt_nxt = edge_cnt;
        ovf_nxt = ovf;
        if (rise) begin
            if (edge_cnt == CNT_MAX) ovf_nxt = 1'b1;
            else                     cnt_nxt = edge_cnt + CNT_W'(1);
        end
        cnt_ext   = 32'(cnt_nxt);
        range_nxt = !ovf_nxt && (cnt_ext >= LIM_LO) && (cnt_ext <= LIM_HI);
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            init_cnt    <= 2'd0;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
            count       <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            unique case (state)
                ST_INIT: begin
                    if (init_cnt == 2'd2) state <= ST_IDLE;
                    else                  init_cnt <= init_cnt + 2'd1;
                end
                ST_IDLE: begin
                    if (enable) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (!enable) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        edge_cnt <= cnt_nxt;
                        ovf      <= ovf_nxt;
                        if (gate_cnt == GATE_LAST) begin
                            count       <= cnt_nxt;
                            overflow    <= ovf_nxt;
                            in_range    <= range_nxt;
                            count_valid <= 1'b1;
                            state       <= ST_REPORT;
                        end else begin
                            gate_cnt <= gate_cnt + GW'(1);
                        end
                    end
                end
                ST_REPORT: begin
                    // Rises here are dropped: a one-cycle dead time per window.
                    if (enable) begin
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                        state    <= ST_GATE;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_meter.sv
// tb_clk_meter: randomized and directed stimulus for clk_meter,
// checked against an edge-counting model over the sampled input history.
module tb_clk_meter;

    localparam int GA = 1000, WA = 16, MINA = 19, MAXA = 21;
    localparam int GB = 3000, WB = 8, MINB = 90, MAXB = 110;
    localparam int HN = 1 << 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sig_a = 1'b0, sig_b = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0;
    logic [WA-1:0] count_a;
    logic [WB-1:0] count_b;
    logic cv_a, ir_a, ov_a, busy_a;
    logic cv_b, ir_b, ov_b, busy_b;

    int total = 0, bad = 0;
    int cyc = 0;
    bit hist_a [HN];
    bit hist_b [HN];

    int mode_a = 0, per_a = 2, req_a = 0;
    int mode_b = 0, per_b = 2, req_b = 0;
    int seen_a = 0, ph_a = 0, hi_a = 2, lo_a = 2;
    int seen_b = 0, ph_b = 0, hi_b = 2, lo_b = 2;

    always #10 clk = ~clk;

    clk_meter #(.GATE_CYCLES(GA), .CNT_W(WA),
                .EXP_MIN(MINA), .EXP_MAX(MAXA)) dut_a (
        .clk_50MHz(clk), .rst_n(rst_n), .sig_in(sig_a),
        .enable(en_a), .count(count_a), .count_valid(cv_a),
        .in_range(ir_a), .overflow(ov_a), .busy(busy_a)
    );

    clk_meter #(.GATE_CYCLES(GB), .CNT_W(WB),
                .EXP_MIN(MINB), .EXP_MAX(MAXB)) dut_b (
        .clk_50MHz(clk), .rst_n(rst_n), .sig_in(sig_b),
        .enable(en_b), .count(count_b), .count_valid(cv_b),
        .in_range(ir_b), .overflow(ov_b), .busy(busy_b)
    );

    // What each meter samples on edge k is hist[k].
    always @(posedge clk) begin
        if (cyc < HN) begin
            hist_a[cyc] = sig_a;
            hist_b[cyc] = sig_b;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (req_a != seen_a) begin
            seen_a = req_a;
            ph_a = 0;
        end
        if (mode_a < 2) sig_a = (mode_a == 1);
        else if (ph_a > 0) ph_a--;
        else begin
            sig_a = ~sig_a;
            if (mode_a == 3) begin
                hi_a = $urandom_range(12, 2);
                lo_a = $urandom_range(12, 2);
            end else begin
                lo_a = per_a / 2;
                hi_a = per_a - lo_a;
            end
            ph_a = (sig_a ? hi_a : lo_a) - 1;
        end
    end

    always @(negedge clk) begin
        if (req_b != seen_b) begin
            seen_b = req_b;
            ph_b = 0;
        end
        if (mode_b < 2) sig_b = (mode_b == 1);
        else if (ph_b > 0) ph_b--;
        else begin
            sig_b = ~sig_b;
            lo_b = per_b / 2;
            hi_b = per_b - lo_b;
            ph_b = (sig_b ? hi_b : lo_b) - 1;
        end
    end

    task automatic check(input string tag, input longint got,
                         input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic set_a(input int m, input int p);
        mode_a = m;
        per_a = p;
        req_a++;
    endtask

    task automatic set_b(input int m, input int p);
        mode_b = m;
        per_b = p;
        req_b++;
    endtask

    // Window ending at edge e covers edges e-G+1..e; each counts
    // a rise that was sampled two and three edges earlier.
    task automatic chk_win(input bit b, input int e);
        int g, w, n, mx, sat;
        bit ov, inr;
        g = b ? GB : GA;
        w = b ? WB : WA;
        n = 0;
        for (int j = e - g + 1; j <= e; j++)
            if (j >= 3 && j < HN && hist_a[0] == hist_a[0])
                if (b ? (hist_b[j-2] && !hist_b[j-3])
                      : (hist_a[j-2] && !hist_a[j-3])) n++;
        mx = (1 << w) - 1;
        ov = n > mx;
        sat = ov ? mx : n;
        inr = !ov && sat >= (b ? MINB : MINA) && sat <= (b ? MAXB : MAXA);
        if (b) begin
            check("b_win_count", count_b, sat);
            check("b_win_ovf", ov_b, ov);
            check("b_win_inr", ir_b, inr);
        end else begin
            check("a_win_count", count_a, sat);
            check("a_win_ovf", ov_a, ov);
            check("a_win_inr", ir_a, inr);
        end
    endtask

    task automatic wait_v(input bit b, input int budget, output int e);
        bit ok;
        ok = 1'b0;
        e = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (b ? cv_b : cv_a) begin
                ok = 1'b1;
                e = cyc - 1;
            end
        end
        check(b ? "b_valid_seen" : "a_valid_seen", ok, 1);
        if (ok) chk_win(b, e);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_count"}, count_a, 0);
        check({tag, "_valid"}, cv_a, 0);
        check({tag, "_inr"}, ir_a, 0);
        check({tag, "_ovf"}, ov_a, 0);
        check({tag, "_busy"}, busy_a, 0);
    endtask

    initial begin
        int e, e0, r, prev, n;
        bit ok, prev_s;

        repeat (3) @(negedge clk);
        chk_zero("rst");

        set_a(2, 50);
        en_a = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        r = cyc;
        wait_v(0, GA + 20, e);
        check("first_edge", e, r + 3 + GA);
        check("1m_count", count_a, 20);
        check("1m_inr", ir_a, 1);
        for (int k = 0; k < 2; k++) begin
            prev = e;
            wait_v(0, GA + 20, e);
            check("period", e - prev, GA + 1);
            check("1m_cont", count_a, 20);
        end

        #1 set_a(2, 5);
        wait_v(0, GA + 20, e);
        wait_v(0, GA + 20, e);
        check("10m_count", count_a, 200);
        check("10m_inr", ir_a, 0);
        check("10m_ovf", ov_a, 0);

        #1 set_a(0, 0);
        repeat (2) wait_v(0, GA + 20, e);
        check("stuck0", count_a, 0);
        #1 set_a(1, 0);
        repeat (2) wait_v(0, GA + 20, e);
        check("stuck1", count_a, 0);
        check("stuck1_inr", ir_a, 0);

        #1 set_a(3, 0);
        repeat (4) wait_v(0, GA + 20, e);

        #1 set_a(2, 50);
        repeat (2) wait_v(0, GA + 20, e);
        check("pre_abort", count_a, 20);
        repeat (400) @(negedge clk);
        check("abort_busy_hi", busy_a, 1);
        #1 en_a = 1'b0;
        @(negedge clk);
        check("abort_busy_lo", busy_a, 0);
        n = 0;
        repeat (1500) begin
            @(negedge clk);
            if (cv_a) n++;
        end
        check("abort_no_valid", n, 0);
        check("abort_hold", count_a, 20);
        #1 en_a = 1'b1;
        e0 = cyc;
        wait_v(0, GA + 20, e);
        check("rearm_edge", e, e0 + GA);
        check("rearm_count", count_a, 20);

        #1 en_a = 1'b0;
        @(negedge clk);
        check("rpt_low_busy", busy_a, 0);
        n = 0;
        repeat (1200) begin
            @(negedge clk);
            if (cv_a) n++;
        end
        check("rpt_low_idle", n, 0);

        #1 en_a = 1'b1;
        repeat (300) @(negedge clk);
        ok = 1'b0;
        prev_s = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (sig_a && !prev_s) ok = 1'b1;
            prev_s = sig_a;
        end
        check("rise_found", ok, 1);
        check("pre_rst_count", count_a, 20);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        r = cyc;
        wait_v(0, GA + 20, e);
        check("post_rst_edge", e, r + 3 + GA);
        check("post_rst_count", count_a, 20);
        check("post_rst_inr", ir_a, 1);
        #1 en_a = 1'b0;

        set_b(2, 5);
        en_b = 1'b1;
        e0 = cyc;
        wait_v(1, GB + 20, e);
        check("b_edge", e, e0 + GB);
        check("b_sat_count", count_b, 255);
        check("b_sat_ovf", ov_b, 1);
        check("b_sat_inr", ir_b, 0);
        #1 en_b = 1'b0;
        set_b(2, 30);
        repeat (10) @(negedge clk);
        #1 en_b = 1'b1;
        wait_v(1, GB + 40, e);
        check("b_100k_count", count_b, 100);
        check("b_100k_ovf", ov_b, 0);
        check("b_100k_inr", ir_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
